// File: rtl/norm_divide.sv
// norm_divide: nine-element x/|v| normalizer on one shared restoring divider; define NORM_ROUND_EN for round-half-up results
module norm_divide #(
  parameter int DW = 10,
  parameter int FW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          magnitude,
  input  logic signed [DW-1:0] elem_a,
  input  logic signed [DW-1:0] elem_b,
  input  logic signed [DW-1:0] elem_c,
  input  logic signed [DW-1:0] elem_d,
  input  logic signed [DW-1:0] elem_e,
  input  logic signed [DW-1:0] elem_f,
  input  logic signed [DW-1:0] elem_g,
  input  logic signed [DW-1:0] elem_h,
  input  logic signed [DW-1:0] elem_i,
  output logic                 busy,
  output logic                 done,
  output logic                 dz,
  output logic signed [FW+1:0] norm_a,
  output logic signed [FW+1:0] norm_b,
  output logic signed [FW+1:0] norm_c,
  output logic signed [FW+1:0] norm_d,
  output logic signed [FW+1:0] norm_e,
  output logic signed [FW+1:0] norm_f,
  output logic signed [FW+1:0] norm_g,
  output logic signed [FW+1:0] norm_h,
  output logic signed [FW+1:0] norm_i
);
`ifdef NORM_ROUND_EN
  localparam int NIT = FW + 2;
`else
  localparam int NIT = FW + 1;
`endif
  localparam int CW = $clog2(NIT + 1);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, DIV = 3'd2, STORE = 3'd3, DONE = 3'd4;
  localparam logic [FW:0] QMAX = {1'b1, {FW{1'b0}}};
  logic [2:0] state;
  logic [3:0] k;
  logic [15:0] mag;
  logic [DW-1:0] elems [9];
  logic [FW+1:0] shadow [9];
  logic [FW+1:0] norm_q [9];
  logic sign, a0, done_q, dz_q;
  logic [16:0] r;
  logic [NIT-1:0] q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] cur, abs_v;
  logic [16:0] r_sh, r_nx;
  logic ge;
  logic [FW:0] q_m, q_c;
  logic [FW+1:0] q_e, res;
  always_comb begin
    cur = elems[k];
    abs_v = cur[DW-1] ? -cur : cur;
    r_sh = {r[15:0], (cnt == CW'(NIT)) ? a0 : 1'b0};
    ge = r_sh >= {1'b0, mag};
    r_nx = ge ? r_sh - {1'b0, mag} : r_sh;
`ifdef NORM_ROUND_EN
    q_m = (FW+1)'(q[NIT-1:1]) + (FW+1)'(q[0]);
`else
    q_m = q;
`endif
    q_c = (mag == 16'd0) ? '0 : (q_m > QMAX ? QMAX : q_m);
    q_e = {1'b0, q_c};
    res = sign ? -q_e : q_e;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= 4'd0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        norm_q[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mag <= magnitude;
          elems[0] <= elem_a;
          elems[1] <= elem_b;
          elems[2] <= elem_c;
          elems[3] <= elem_d;
          elems[4] <= elem_e;
          elems[5] <= elem_f;
          elems[6] <= elem_g;
          elems[7] <= elem_h;
          elems[8] <= elem_i;
          k <= 4'd0;
          state <= LOAD;
        end
        LOAD: begin
          sign <= cur[DW-1];
          a0 <= abs_v[0];
          r <= 17'(abs_v >> 1);
          q <= '0;
          cnt <= CW'(NIT);
          state <= DIV;
        end
        DIV: begin
          r <= r_nx;
          q <= {q[NIT-2:0], ge};
          cnt <= cnt - CW'(1);
          state <= (cnt == CW'(1)) ? STORE : DIV;
        end
        STORE: begin
          shadow[k] <= res;
          k <= k + 4'd1;
          state <= (k == 4'd8) ? DONE : LOAD;
        end
        DONE: begin
          norm_q <= shadow;
          dz_q <= mag == 16'd0;
          done_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign done = done_q;
  assign dz = dz_q;
  assign norm_a = norm_q[0];
  assign norm_b = norm_q[1];
  assign norm_c = norm_q[2];
  assign norm_d = norm_q[3];
  assign norm_e = norm_q[4];
  assign norm_f = norm_q[5];
  assign norm_g = norm_q[6];
  assign norm_h = norm_q[7];
  assign norm_i = norm_q[8];
endmodule

// File: tb/tb_norm_divide.sv
// tb_norm_divide: table-driven scoreboard bench for norm_divide
module tb_norm_divide;
`ifdef NORM_ROUND_EN
  localparam int LAT = 109;
`else
  localparam int LAT = 100;
`endif
  typedef struct packed {
    logic [8:0][9:0] e;
    logic [15:0] m;
    logic [8:0][9:0] n;
    logic dz;
  } vec_t;
  logic clk = 0, rst, start, busy, done, dz;
  logic [15:0] mag;
  logic [9:0] ei [9];
  logic [9:0] nq [9];
  int checks = 0, failures = 0;
  vec_t sb [$];
  vec_t tbl [12];
  logic pd = 0;
  always #5 clk = ~clk;
  norm_divide dut (
    .clk(clk), .rst(rst), .start(start), .magnitude(mag),
    .elem_a(ei[0]), .elem_b(ei[1]), .elem_c(ei[2]), .elem_d(ei[3]), .elem_e(ei[4]),
    .elem_f(ei[5]), .elem_g(ei[6]), .elem_h(ei[7]), .elem_i(ei[8]),
    .busy(busy), .done(done), .dz(dz),
    .norm_a(nq[0]), .norm_b(nq[1]), .norm_c(nq[2]), .norm_d(nq[3]), .norm_e(nq[4]),
    .norm_f(nq[5]), .norm_g(nq[6]), .norm_h(nq[7]), .norm_i(nq[8])
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic logic [9:0] model(input logic [9:0] x, input logic [15:0] m);
    int ax, q;
    ax = x[9] ? 1024 - int'(x) : int'(x);
    if (m == 16'd0) return 10'd0;
`ifdef NORM_ROUND_EN
    q = ((ax * 512) / int'(m) + 1) / 2;
`else
    q = (ax * 256) / int'(m);
`endif
    return x[9] ? 10'(-q) : 10'(q);
  endfunction
  function automatic vec_t fin(input vec_t v);
    vec_t o = v;
    for (int j = 0; j < 9; j++) o.n[j] = model(v.e[j], v.m);
    o.dz = v.m == 16'd0;
    return o;
  endfunction
  function automatic int isqrt(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction
  always @(negedge clk) begin
    if (done) begin
      vec_t v;
      chk("done_single_cycle", 32'(pd), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        v = sb.pop_front();
        for (int j = 0; j < 9; j++) chk($sformatf("norm[%0d]", j), 32'(nq[j]), 32'(v.n[j]));
        chk("dz", 32'(dz), 32'(v.dz));
      end
    end
    pd = done;
  end
  task automatic apply(input vec_t v, input int p1, input int p2, input int rst_at);
    int cyc, nd;
    bit seen;
    @(negedge clk);
    for (int j = 0; j < 9; j++) ei[j] = v.e[j];
    mag = v.m;
    start = 1;
    sb.push_back(v);
    @(posedge clk);
    #1 start = 0;
    for (int j = 0; j < 9; j++) ei[j] = 10'($urandom);
    mag = 16'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      if (rst_at != 0 && cyc == rst_at) begin
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("busy_after_rst", 32'(busy), 32'd0);
        chk("dz_after_rst", 32'(dz), 32'd0);
        for (int j = 0; j < 9; j++) chk($sformatf("norm_rst[%0d]", j), 32'(nq[j]), 32'd0);
        void'(sb.pop_back());
        nd = 0;
        repeat (120) begin
          @(posedge clk);
          #1 if (done) nd++;
        end
        chk("no_done_after_rst", 32'(nd), 32'd0);
        return;
      end
      if ((p1 != 0 && cyc == p1) || (p2 != 0 && cyc == p2)) start = 1;
      @(posedge clk);
      #1 start = 0;
      cyc++;
      seen = done;
    end
    chk("latency", 32'(cyc), 32'(LAT));
  endtask
  initial begin
    vec_t v;
    int s, x, nd;
    rst = 1;
    start = 0;
    mag = 0;
    for (int j = 0; j < 9; j++) ei[j] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    for (int j = 0; j < 9; j++) chk($sformatf("rst_norm[%0d]", j), 32'(nq[j]), 32'd0);
    rst = 0;
    v = '0; v.e[0] = 10'd3; v.e[1] = 10'd4; v.m = 16'd5; tbl[0] = fin(v);
`ifdef NORM_ROUND_EN
    tbl[0].n[0] = 10'd154; tbl[0].n[1] = 10'd205;
`else
    tbl[0].n[0] = 10'd153; tbl[0].n[1] = 10'd204;
`endif
    v = '0; v.e[0] = -10'sd3; v.e[1] = -10'sd4; v.m = 16'd5; tbl[1] = fin(v);
`ifdef NORM_ROUND_EN
    tbl[1].n[0] = 10'h366; tbl[1].n[1] = 10'h333;
`else
    tbl[1].n[0] = 10'h367; tbl[1].n[1] = 10'h334;
`endif
    v = '0; v.e[4] = -10'sd100; v.m = 16'd100; tbl[2] = fin(v); tbl[2].n[4] = 10'h300;
    v = '0; tbl[3] = fin(v); tbl[3].dz = 1'b1;
    tbl[4] = tbl[0];
    v = '0; v.e[8] = 10'h200; v.m = 16'd512; tbl[5] = fin(v); tbl[5].n[8] = 10'h300;
    v = '0; v.e[0] = 10'd50; v.e[3] = -10'sd7; tbl[6] = fin(v); tbl[6].dz = 1'b1;
    v = '0; v.e[2] = 10'd7; v.e[6] = -10'sd7; v.m = 16'd1000; tbl[7] = fin(v);
    for (int t = 8; t < 12; t++) begin
      v = '0;
      s = 0;
      for (int j = 0; j < 9; j++) begin
        x = int'($urandom_range(724)) - 362;
        v.e[j] = 10'(x);
        s += x * x;
      end
      v.m = 16'(isqrt(s));
      tbl[t] = fin(v);
    end
    for (int t = 0; t < 12; t++) apply(tbl[t], 0, 0, 0);
    apply(tbl[0], 10, 50, 0);
    apply(tbl[1], 0, 0, 40);
    apply(tbl[0], 0, 0, 0);
    @(negedge clk);
    for (int j = 0; j < 9; j++) ei[j] = 10'd3;
    mag = 16'd5;
    start = 1;
    rst = 1;
    @(posedge clk);
    #1 start = 0;
    rst = 0;
    chk("rst_beats_start_busy", 32'(busy), 32'd0);
    nd = 0;
    repeat (110) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("rst_beats_start_no_done", 32'(nd), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
